// File: rtl/axis_img_border_gen_pkg.sv
// Shared state encodings and marker-bit defaults for the border generator and the stages around it.
package axis_img_border_gen_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_TOP,
    ST_LEFT,
    ST_PIX,
    ST_RIGHT,
    ST_BOTTOM
  } state_t;

  localparam logic [15:0] DEFAULT_BYPASS_MASK = 16'h8000;
  localparam int          CNT_W               = 13;

  function automatic logic [15:0] border_word(input logic [15:0] value, input logic [15:0] mask);
    return value & ~mask;
  endfunction

endpackage

// File: rtl/axis_img_border_gen.sv
// Wraps each AXI-Stream frame in a constant border; one output register stage, one clock of latency.
// Border beats flow without input; s_axis is back-pressured outside ST_PIX and whenever the output register cannot load.
module axis_img_border_gen
  import axis_img_border_gen_pkg::*;
#(
  parameter int          IMG_WIDTH       = 640,
  parameter int          IMG_HEIGHT      = 480,
  parameter int          BORDER          = 1,
  parameter logic [15:0] BYPASS_BIT_MASK = DEFAULT_BYPASS_MASK,
  parameter logic [15:0] BORDER_VALUE    = 16'h0000
) (
  input  logic        axis_aclk,
  input  logic        axis_areset,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        err_line_len
);

  localparam int OUT_W = IMG_WIDTH + 2 * BORDER;
  localparam int OUT_H = IMG_HEIGHT + 2 * BORDER;

  localparam logic [CNT_W-1:0] COL_LAST     = CNT_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0] COL_LEFT_END = CNT_W'(BORDER - 1);
  localparam logic [CNT_W-1:0] COL_PIX_END  = CNT_W'(BORDER + IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_TOP_END  = CNT_W'(BORDER - 1);
  localparam logic [CNT_W-1:0] ROW_PIX_END  = CNT_W'(BORDER + IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] ROW_LAST     = CNT_W'(OUT_H - 1);
  localparam logic [15:0]      BORDER_WORD  = border_word(BORDER_VALUE, BYPASS_BIT_MASK);

  state_t           r_state;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic             r_m_vld;
  logic             r_m_last;
  logic [15:0]      r_m_dat;
  logic             r_err;

  logic w_load;
  logic w_is_border;
  logic w_fire;
  logic w_col_last;

  assign w_load      = !r_m_vld || m_axis_tready;
  assign w_is_border = (r_state == ST_TOP) || (r_state == ST_LEFT) ||
                       (r_state == ST_RIGHT) || (r_state == ST_BOTTOM);
  assign w_fire      = w_load && (w_is_border || ((r_state == ST_PIX) && s_axis_tvalid));
  assign w_col_last  = (r_col == COL_LAST);

  assign s_axis_tready = !axis_areset && (r_state == ST_PIX) && w_load;
  assign m_axis_tdata  = r_m_dat;
  assign m_axis_tvalid = r_m_vld;
  assign m_axis_tlast  = r_m_last;
  assign err_line_len  = r_err;

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_state  <= ST_RST;
      r_col    <= '0;
      r_row    <= '0;
      r_m_vld  <= 1'b0;
      r_m_last <= 1'b0;
      r_m_dat  <= '0;
      r_err    <= 1'b0;
    end else begin
      // Column and row follow the fixed output geometry; input tlast only raises the flag.
      r_err <= s_axis_tready && s_axis_tvalid && (s_axis_tlast != (r_col == COL_PIX_END));

      if (m_axis_tready) begin
        r_m_vld <= 1'b0;
      end
      if (w_fire) begin
        r_m_vld  <= 1'b1;
        r_m_last <= w_col_last;
        r_m_dat  <= (r_state == ST_PIX) ? (s_axis_tdata | BYPASS_BIT_MASK) : BORDER_WORD;
        r_col    <= w_col_last ? '0 : r_col + 1'b1;
      end

      case (r_state)
        ST_RST: r_state <= ST_TOP;
        ST_TOP: begin
          if (w_fire && w_col_last) begin
            r_row <= r_row + 1'b1;
            if (r_row == ROW_TOP_END) r_state <= ST_LEFT;
          end
        end
        ST_LEFT: begin
          if (w_fire && (r_col == COL_LEFT_END)) r_state <= ST_PIX;
        end
        ST_PIX: begin
          if (w_fire && (r_col == COL_PIX_END)) r_state <= ST_RIGHT;
        end
        ST_RIGHT: begin
          if (w_fire && w_col_last) begin
            r_row   <= r_row + 1'b1;
            r_state <= (r_row == ROW_PIX_END) ? ST_BOTTOM : ST_LEFT;
          end
        end
        ST_BOTTOM: begin
          if (w_fire && w_col_last) begin
            if (r_row == ROW_LAST) begin
              r_row   <= '0;
              r_state <= ST_TOP;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        default: r_state <= ST_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_img_border_gen.sv
// Scoreboard bench: a frame-level model queues expected beats and input pixels; drivers and monitors
// run as independent processes and compare on every output handshake.
`timescale 1ns/1ps
module tb_axis_img_border_gen;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
    int          gap;
  } pix_t;

  localparam int          AW = 4, AH = 3, AB = 1;
  localparam int          BW = 4, BH = 3, BB = 2;
  localparam logic [15:0] A_MASK = 16'h8000, A_BV = 16'h0000;
  localparam logic [15:0] B_MASK = 16'h8000, B_BV = 16'h8123;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_s_vld, a_s_rdy, a_s_last, a_m_vld, a_m_rdy, a_m_last, a_err;
  logic [15:0] a_s_dat, a_m_dat;
  logic        b_s_vld, b_s_rdy, b_s_last, b_m_vld, b_m_rdy, b_m_last, b_err;
  logic [15:0] b_s_dat, b_m_dat;

  axis_img_border_gen #(
    .IMG_WIDTH(AW), .IMG_HEIGHT(AH), .BORDER(AB), .BYPASS_BIT_MASK(A_MASK), .BORDER_VALUE(A_BV)
  ) dut_a (
    .axis_aclk(clk), .axis_areset(rst),
    .s_axis_tdata(a_s_dat), .s_axis_tvalid(a_s_vld), .s_axis_tready(a_s_rdy), .s_axis_tlast(a_s_last),
    .m_axis_tdata(a_m_dat), .m_axis_tvalid(a_m_vld), .m_axis_tready(a_m_rdy), .m_axis_tlast(a_m_last),
    .err_line_len(a_err)
  );

  axis_img_border_gen #(
    .IMG_WIDTH(BW), .IMG_HEIGHT(BH), .BORDER(BB), .BYPASS_BIT_MASK(B_MASK), .BORDER_VALUE(B_BV)
  ) dut_b (
    .axis_aclk(clk), .axis_areset(rst),
    .s_axis_tdata(b_s_dat), .s_axis_tvalid(b_s_vld), .s_axis_tready(b_s_rdy), .s_axis_tlast(b_s_last),
    .m_axis_tdata(b_m_dat), .m_axis_tvalid(b_m_vld), .m_axis_tready(b_m_rdy), .m_axis_tlast(b_m_last),
    .err_line_len(b_err)
  );

  beat_t exp_a[$], exp_b[$];
  pix_t  in_a[$], in_b[$];
  int    n_cmp = 0, n_err = 0;
  int    out_cnt_a = 0, out_cnt_b = 0;
  int    err_seen_a = 0, err_exp_a = 0, err_seen_b = 0;
  int    mode = 0;  // 0: ready always, 1: ready toggles 1010, 2: random ready
  bit    acc_a = 1'b0, acc_b = 1'b0;
  bit    prev_stall_a = 1'b0;
  beat_t prev_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: builds one whole frame from the geometry rules.
  task automatic gen_frame(input bit to_b, input bit seq, input int stall_idx,
                           input int bad_row, input int gap_max);
    int          w, h, b, idx;
    logic [15:0] bv, mask;
    w    = to_b ? BW : AW;
    h    = to_b ? BH : AH;
    b    = to_b ? BB : AB;
    bv   = to_b ? B_BV : A_BV;
    mask = to_b ? B_MASK : A_MASK;
    idx  = 0;
    for (int r = 0; r < h + 2 * b; r++) begin
      for (int c = 0; c < w + 2 * b; c++) begin
        beat_t e;
        pix_t  p;
        e.l = (c == w + 2 * b - 1);
        if (r < b || r >= h + b || c < b || c >= w + b) begin
          e.d = bv & ~mask;
        end else begin
          p.d   = seq ? 16'(idx + 1) : 16'($urandom);
          p.l   = (c - b == w - 1) || (r - b == bad_row && c - b == w - 2);
          p.gap = (idx == stall_idx) ? 5 :
                  (gap_max > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, gap_max)) : 0;
          if (!to_b && (p.l != (c - b == w - 1))) err_exp_a++;
          e.d = p.d | mask;
          if (to_b) in_b.push_back(p);
          else in_a.push_back(p);
          idx++;
        end
        if (to_b) exp_b.push_back(e);
        else exp_a.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_a.size() + in_a.size() + exp_b.size() + in_b.size()) > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drained"}, 32'(exp_a.size() + exp_b.size() + in_a.size() + in_b.size()), 32'd0);
  endtask

  initial begin : drv_a
    int gap = -1;
    a_s_vld = 1'b0; a_s_dat = '0; a_s_last = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        a_s_vld = 1'b0;
        gap     = -1;
      end else begin
        if (acc_a) begin
          void'(in_a.pop_front());
          gap = -1;
        end
        a_s_vld = 1'b0;
        if (in_a.size() > 0) begin
          if (gap < 0) gap = in_a[0].gap;
          if (gap > 0) gap--;
          else begin
            a_s_vld  = 1'b1;
            a_s_dat  = in_a[0].d;
            a_s_last = in_a[0].l;
          end
        end
      end
    end
  end

  initial begin : drv_b
    b_s_vld = 1'b0; b_s_dat = '0; b_s_last = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && acc_b) void'(in_b.pop_front());
      b_s_vld = !rst && (in_b.size() > 0);
      if (in_b.size() > 0) begin
        b_s_dat  = in_b[0].d;
        b_s_last = in_b[0].l;
      end
    end
  end

  // Downstream only accepts beats the model has predicted, so idle border generation stays parked.
  initial begin : drv_rdy
    bit tog = 1'b1;
    a_m_rdy = 1'b0; b_m_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      b_m_rdy = (exp_b.size() > 0);
      if (exp_a.size() == 0) a_m_rdy = 1'b0;
      else case (mode)
        0:       a_m_rdy = 1'b1;
        1:       a_m_rdy = tog;
        default: a_m_rdy = ($urandom_range(0, 3) != 0);
      endcase
      tog = !tog;
    end
  end

  always @(negedge clk) begin
    acc_a = a_s_vld && a_s_rdy;
    acc_b = b_s_vld && b_s_rdy;
    if (rst) begin
      prev_stall_a = 1'b0;
    end else begin
      if (prev_stall_a) begin
        chk("hold_vld_a", 32'(a_m_vld), 32'd1);
        chk("hold_beat_a", 32'({a_m_dat, a_m_last}), 32'(prev_a));
      end
      if (a_m_vld && a_m_rdy) begin
        if (exp_a.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL beat_a: got %h, expected no beat", {a_m_dat, a_m_last});
        end else begin
          chk($sformatf("beat_a_%0d", out_cnt_a), 32'({a_m_dat, a_m_last}), 32'(exp_a.pop_front()));
        end
        out_cnt_a++;
      end
      prev_stall_a = a_m_vld && !a_m_rdy;
      prev_a       = {a_m_dat, a_m_last};
      if (a_err) err_seen_a++;
      if (b_m_vld && b_m_rdy) begin
        if (exp_b.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL beat_b: got %h, expected no beat", {b_m_dat, b_m_last});
        end else begin
          chk($sformatf("beat_b_%0d", out_cnt_b), 32'({b_m_dat, b_m_last}), 32'(exp_b.pop_front()));
        end
        out_cnt_b++;
      end
      if (b_err) err_seen_b++;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_vld"}, 32'(a_m_vld), 32'd0);
    chk({tag, "_m_last"}, 32'(a_m_last), 32'd0);
    chk({tag, "_m_dat"}, 32'(a_m_dat), 32'd0);
    chk({tag, "_err"}, 32'(a_err), 32'd0);
    chk({tag, "_s_rdy"}, 32'(a_s_rdy), 32'd0);
    chk({tag, "_b_m_vld"}, 32'(b_m_vld), 32'd0);
  endtask

  initial begin : main
    int n, bub, base;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    // Pixels 1..12 with everything flowing, plus a random follow-on frame behind it.
    mode = 0;
    gen_frame(1'b0, 1'b1, -1, -1, 0);
    gen_frame(1'b0, 1'b0, -1, -1, 0);
    n = 0; bub = 0;
    @(negedge clk);
    while (!a_m_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 30; i++) begin
      if (!(a_m_vld && a_m_rdy)) bub++;
      @(negedge clk);
    end
    chk("no_bubbles", 32'(bub), 32'd0);
    wait_done("cont", 400);

    mode = 1;
    gen_frame(1'b0, 1'b0, -1, -1, 0);
    wait_done("toggle", 400);

    // Input valid drops for 5 clocks at image row 2 column 2.
    mode = 0;
    gen_frame(1'b0, 1'b1, 5, -1, 0);
    wait_done("stall", 400);

    mode = 2;
    for (int f = 0; f < 3; f++) gen_frame(1'b0, 1'b0, -1, (f == 1) ? 1 : -1, 3);
    wait_done("random", 2000);
    repeat (3) @(posedge clk);
    chk("err_pulses", 32'(err_seen_a), 32'(err_exp_a));

    // Reset with output beat 15 in flight.
    mode = 0;
    base = out_cnt_a;
    gen_frame(1'b0, 1'b0, -1, -1, 0);
    n = 0;
    while (out_cnt_a < base + 14 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_beat15", 32'(out_cnt_a - base), 32'd14);
    @(posedge clk); #2;
    rst = 1'b1;
    exp_a.delete();
    in_a.delete();
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    gen_frame(1'b0, 1'b0, -1, -1, 0);
    wait_done("post_reset", 400);

    gen_frame(1'b1, 1'b0, -1, -1, 0);
    wait_done("border2", 400);
    chk("b_frame_beats", 32'(out_cnt_b), 32'd56);
    chk("b_err_pulses", 32'(err_seen_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish within 2 ms");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule
